// File: rtl/pc_unit.sv
// Program-counter stage: sequences start/halt, steps the instruction address,
// and redirects it through a loadable branch-target LUT when the ALU takes a branch.
module pc_unit #(
  parameter int PC_W       = 10,
  parameter int LUT_AW     = 5,
  parameter int START_ADDR = 0
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              branch,
  input  logic              abs_jump,
  input  logic [LUT_AW-1:0] target_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   prog_addr,
  output logic              run,
  output logic              done,
  output logic [15:0]       cycle_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int LUT_DEPTH = 2 ** LUT_AW;
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  state_t          state, state_next;
  logic [PC_W-1:0] pc_next;
  logic [15:0]     count_next;
  logic [PC_W-1:0] lut [LUT_DEPTH];
  logic [PC_W-1:0] lut_entry;

  // Relative entries are two's-complement, so a plain modular add handles negatives.
  assign lut_entry = lut[target_idx];

  always_comb begin
    state_next = state;
    pc_next    = prog_addr;
    count_next = cycle_count;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = START_PC;
          count_next = '0;
        end
      end
      RUN: begin
        if (halt) begin
          state_next = DONE;
        end else if (branch) begin
          pc_next = abs_jump ? lut_entry : prog_addr + lut_entry;
        end else begin
          pc_next = prog_addr + 1'b1;
        end
        if (cycle_count != 16'hFFFF) begin
          count_next = cycle_count + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prog_addr   <= START_PC;
      cycle_count <= '0;
    end else begin
      state       <= state_next;
      prog_addr   <= pc_next;
      cycle_count <= count_next;
    end
  end

  // Reads in the writing cycle see the old entry, since the write lands on the edge.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  assign run  = (state == RUN);
  assign done = (state == DONE);

endmodule
